// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and DMA read-engine types.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  localparam int unsigned MAX_BURST_BEATS = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dma_rd_burst_calc.sv
// Sizes the next INCR burst from the current address and words still to request.
module dma_rd_burst_calc #(
  parameter int unsigned BITS_TRANS   = 18,
  parameter int unsigned AXI_WIDTH_AD = 32,
  parameter int unsigned AXI_WIDTH_DS = 4,
  parameter int unsigned MAX_BEATS    = 32,
  parameter int unsigned BEAT_W       = 6
) (
  input  logic [AXI_WIDTH_AD-1:0] i_addr,
  input  logic [BITS_TRANS-1:0]   i_remaining,
  output logic [7:0]              o_arlen_c,
  output logic [BEAT_W-1:0]       o_beats_c,
  output logic [AXI_WIDTH_AD-1:0] o_next_addr_c
);

  logic [BEAT_W-1:0] w_beats;

  // Beats in this burst: the smaller of what is left and the burst ceiling.
  always_comb begin
    w_beats = BEAT_W'(MAX_BEATS);
    if (i_remaining < BITS_TRANS'(MAX_BEATS)) begin
      w_beats = BEAT_W'(i_remaining);
    end
  end

  assign o_beats_c     = w_beats;
  assign o_arlen_c     = 8'(w_beats) - 8'd1;
  assign o_next_addr_c = i_addr + (AXI_WIDTH_AD'(w_beats) * AXI_WIDTH_AD'(AXI_WIDTH_DS));

endmodule

// File: rtl/axi_dma_rd_engine.sv
// AXI4 read-only DMA master: fetches a word block in INCR bursts and streams it out.
module axi_dma_rd_engine
  import axi_pkg::*;
#(
  parameter int unsigned BITS_TRANS     = 18,
  parameter int unsigned OUT_BITS_TRANS = 13,
  parameter int unsigned AXI_WIDTH_USER = 1,
  parameter int unsigned AXI_WIDTH_ID   = 4,
  parameter int unsigned AXI_WIDTH_AD   = 32,
  parameter int unsigned AXI_WIDTH_DA   = 32,
  parameter int unsigned AXI_WIDTH_DS   = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  output logic [AXI_WIDTH_AD-1:0]   M_ARADDR,
  output logic [AXI_WIDTH_ID-1:0]   M_ARID,
  output logic [7:0]                M_ARLEN,
  output logic [2:0]                M_ARSIZE,
  output logic [1:0]                M_ARBURST,
  output logic [1:0]                M_ARLOCK,
  output logic [3:0]                M_ARCACHE,
  output logic [2:0]                M_ARPROT,
  output logic [3:0]                M_ARQOS,
  output logic [3:0]                M_ARREGION,
  output logic [AXI_WIDTH_USER-1:0] M_ARUSER,
  input  logic                      M_RVALID,
  output logic                      M_RREADY,
  input  logic [AXI_WIDTH_DA-1:0]   M_RDATA,
  input  logic                      M_RLAST,
  input  logic [AXI_WIDTH_ID-1:0]   M_RID,
  input  logic [AXI_WIDTH_USER-1:0] M_RUSER,
  input  logic [1:0]                M_RRESP,
  input  logic                      start_dma,
  input  logic [BITS_TRANS-1:0]     num_trans,
  input  logic [AXI_WIDTH_AD-1:0]   start_addr,
  output logic [AXI_WIDTH_DA-1:0]   data_o,
  output logic                      data_vld_o,
  output logic [BITS_TRANS-1:0]     data_cnt_o,
  output logic                      done_o
);

  localparam int unsigned MAX_BEATS = 32'd1 << (BITS_TRANS - OUT_BITS_TRANS);
  localparam int unsigned BEAT_W    = $clog2(MAX_BEATS + 1);

  dma_state_e r_state;
  dma_state_e w_next_state;

  logic [AXI_WIDTH_AD-1:0] r_addr;
  logic [BITS_TRANS-1:0]   r_req_left;
  logic [BITS_TRANS-1:0]   r_remaining;
  logic [BEAT_W-1:0]       r_burst_left;
  logic [BITS_TRANS-1:0]   r_cnt;

  logic [AXI_WIDTH_AD-1:0] w_calc_addr;
  logic [BITS_TRANS-1:0]   w_calc_left;
  logic [7:0]              w_arlen_c;
  logic [BEAT_W-1:0]       w_beats_c;
  logic [AXI_WIDTH_AD-1:0] w_next_addr_c;
  logic                    w_ar_hs;
  logic                    w_r_hs;
  logic                    w_burst_end;
  logic                    w_start;
  logic                    w_unused;

  assign M_ARID     = '0;
  assign M_ARSIZE   = AXI_SIZE_4B;
  assign M_ARBURST  = AXI_BURST_INCR;
  assign M_ARLOCK   = 2'b00;
  assign M_ARCACHE  = 4'b0000;
  assign M_ARPROT   = 3'b000;
  assign M_ARQOS    = 4'b0000;
  assign M_ARREGION = 4'b0000;
  assign M_ARUSER   = '0;

  // ID, user and response of read beats carry no meaning for this engine.
  assign w_unused = ^{M_RID, M_RUSER, M_RRESP};

  assign w_start     = (r_state == ST_IDLE) && start_dma;
  assign w_ar_hs     = M_ARVALID && M_ARREADY;
  assign w_r_hs      = M_RVALID && M_RREADY && (r_state == ST_DATA);
  assign w_burst_end = w_r_hs && (M_RLAST || (r_burst_left == BEAT_W'(1)));

  // The first burst is sized straight from the request; later ones from the latched progress.
  assign w_calc_addr = (r_state == ST_IDLE) ? start_addr : r_addr;
  assign w_calc_left = (r_state == ST_IDLE) ? num_trans  : r_req_left;

  dma_rd_burst_calc #(
    .BITS_TRANS   (BITS_TRANS),
    .AXI_WIDTH_AD (AXI_WIDTH_AD),
    .AXI_WIDTH_DS (AXI_WIDTH_DS),
    .MAX_BEATS    (MAX_BEATS),
    .BEAT_W       (BEAT_W)
  ) u_burst_calc (
    .i_addr        (w_calc_addr),
    .i_remaining   (w_calc_left),
    .o_arlen_c     (w_arlen_c),
    .o_beats_c     (w_beats_c),
    .o_next_addr_c (w_next_addr_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one outstanding burst, loop ADDR/DATA until every word arrives.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_dma) begin
          w_next_state = (num_trans == '0) ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (w_ar_hs) begin
          w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_burst_end) begin
          w_next_state = (r_remaining == BITS_TRANS'(1)) ? ST_DONE : ST_ADDR;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Registered AXI controls, transfer bookkeeping and client outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      M_ARVALID    <= 1'b0;
      M_RREADY     <= 1'b0;
      M_ARADDR     <= '0;
      M_ARLEN      <= '0;
      data_o       <= '0;
      data_vld_o   <= 1'b0;
      data_cnt_o   <= '0;
      done_o       <= 1'b0;
      r_addr       <= '0;
      r_req_left   <= '0;
      r_remaining  <= '0;
      r_burst_left <= '0;
      r_cnt        <= '0;
    end else begin
      data_vld_o <= 1'b0;
      done_o     <= (r_state == ST_DONE);
      M_ARVALID  <= (w_next_state == ST_ADDR);
      M_RREADY   <= (w_next_state == ST_DATA);

      // AR payload is loaded only on entry to ADDR so it stays put until accepted.
      if ((r_state != ST_ADDR) && (w_next_state == ST_ADDR)) begin
        M_ARADDR <= w_calc_addr;
        M_ARLEN  <= w_arlen_c;
      end

      if (w_start) begin
        r_addr      <= start_addr;
        r_req_left  <= num_trans;
        r_remaining <= num_trans;
        r_cnt       <= '0;
      end

      if (w_ar_hs) begin
        r_addr       <= w_next_addr_c;
        r_req_left   <= r_req_left - BITS_TRANS'(w_beats_c);
        r_burst_left <= w_beats_c;
      end

      if (w_r_hs) begin
        data_o       <= M_RDATA;
        data_vld_o   <= 1'b1;
        data_cnt_o   <= r_cnt;
        r_cnt        <= r_cnt + BITS_TRANS'(1);
        r_remaining  <= r_remaining - BITS_TRANS'(1);
        r_burst_left <= r_burst_left - BEAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_dma_rd_engine.sv
// Bench for axi_dma_rd_engine: randomised AXI slave plus a burst/word reference model.
module tb_axi_dma_rd_engine;

  localparam int unsigned BT = 18;
  localparam int unsigned AD = 32;
  localparam int unsigned DA = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned UW = 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          M_ARVALID, M_ARREADY;
  logic [AD-1:0] M_ARADDR;
  logic [IW-1:0] M_ARID;
  logic [7:0]    M_ARLEN;
  logic [2:0]    M_ARSIZE;
  logic [1:0]    M_ARBURST, M_ARLOCK;
  logic [3:0]    M_ARCACHE, M_ARQOS, M_ARREGION;
  logic [2:0]    M_ARPROT;
  logic [UW-1:0] M_ARUSER;
  logic          M_RVALID, M_RREADY, M_RLAST;
  logic [DA-1:0] M_RDATA;
  logic [IW-1:0] M_RID;
  logic [UW-1:0] M_RUSER;
  logic [1:0]    M_RRESP;
  logic          start_dma;
  logic [BT-1:0] num_trans;
  logic [AD-1:0] start_addr;
  logic [DA-1:0] data_o;
  logic          data_vld_o;
  logic [BT-1:0] data_cnt_o;
  logic          done_o;

  always #5 clk = ~clk;

  axi_dma_rd_engine dut (
    .clk(clk), .rstn(rstn),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR), .M_ARID(M_ARID),
    .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARLOCK(M_ARLOCK),
    .M_ARCACHE(M_ARCACHE), .M_ARPROT(M_ARPROT), .M_ARQOS(M_ARQOS), .M_ARREGION(M_ARREGION),
    .M_ARUSER(M_ARUSER), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA),
    .M_RLAST(M_RLAST), .M_RID(M_RID), .M_RUSER(M_RUSER), .M_RRESP(M_RRESP),
    .start_dma(start_dma), .num_trans(num_trans), .start_addr(start_addr),
    .data_o(data_o), .data_vld_o(data_vld_o), .data_cnt_o(data_cnt_o), .done_o(done_o)
  );

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave configuration and memory contents (word at byte address a = (a>>2) ^ salt).
  int unsigned ar_delay = 0;
  int unsigned rv_pct = 100;
  logic [31:0] salt = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) ^ salt;
  endfunction

  // Observations collected by the slave/monitor.
  logic [31:0] got_ar_addr[$];
  logic [7:0]  got_ar_len[$];
  logic [31:0] got_data[$];
  logic [BT-1:0] got_cnt[$];
  int done_cnt = 0;
  int vld_err = 0;
  int ar_unstable = 0;
  int unsigned last_vld_cyc = 0;
  int unsigned done_cyc = 0;

  task automatic clear_mon();
    got_ar_addr.delete(); got_ar_len.delete(); got_data.delete(); got_cnt.delete();
    done_cnt = 0; vld_err = 0; ar_unstable = 0; last_vld_cyc = 0; done_cyc = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // AXI slave and output monitor, all on the falling edge.
  logic        b_act = 1'b0;
  logic [31:0] b_addr = '0;
  int          b_len = 0, b_idx = 0;
  int unsigned ar_wait = 0;
  logic        prev_r_hs = 1'b0, ar_pend = 1'b0, ar_hs, r_hs;
  logic [31:0] prev_rdata = '0, pend_addr = '0;
  logic [7:0]  pend_len = '0;

  initial begin
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RLAST = 1'b0;
    M_RID = '0; M_RUSER = '0; M_RRESP = 2'b00;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RLAST = 1'b0;
        b_act = 1'b0; ar_wait = 0; prev_r_hs = 1'b0; ar_pend = 1'b0;
      end else begin
        if (data_vld_o) begin
          if (!prev_r_hs || (data_o !== prev_rdata)) vld_err++;
          got_data.push_back(data_o);
          got_cnt.push_back(data_cnt_o);
          last_vld_cyc = cyc;
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (ar_pend && (!M_ARVALID || (M_ARADDR !== pend_addr) || (M_ARLEN !== pend_len))) ar_unstable++;

        M_ARREADY = 1'b0;
        if (M_ARVALID && !b_act) begin
          if (ar_wait >= ar_delay) M_ARREADY = 1'b1;
          else ar_wait++;
        end
        ar_hs = M_ARVALID && M_ARREADY;

        M_RVALID = 1'b0; M_RLAST = 1'b0; M_RDATA = $urandom;
        if (b_act && ($urandom_range(0, 99) < rv_pct)) begin
          M_RVALID = 1'b1;
          M_RDATA  = mem_word(b_addr + 32'(4 * b_idx));
          M_RLAST  = (b_idx == b_len);
        end
        r_hs = M_RVALID && M_RREADY;
        prev_rdata = M_RDATA;
        if (r_hs) begin
          b_idx++;
          if (b_idx > b_len) b_act = 1'b0;
        end
        if (ar_hs) begin
          b_act = 1'b1; b_addr = M_ARADDR; b_len = int'(M_ARLEN); b_idx = 0; ar_wait = 0;
          got_ar_addr.push_back(M_ARADDR);
          got_ar_len.push_back(M_ARLEN);
        end
        prev_r_hs = r_hs;
        ar_pend = M_ARVALID && !ar_hs;
        pend_addr = M_ARADDR;
        pend_len = M_ARLEN;
      end
    end
  end

  // One complete request checked against the reference burst split and word stream.
  task automatic run_xfer(input int n, input logic [31:0] addr, input int unsigned ard,
                          input int unsigned rvp, input bit dup);
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_len[$];
    logic [31:0] a;
    int left, b, nar, nd;
    int unsigned c0;
    bit timeout, dup_done;
    a = addr; left = n;
    while (left > 0) begin
      b = (left > 32) ? 32 : left;
      exp_addr.push_back(a);
      exp_len.push_back(8'(b - 1));
      a = a + 32'(4 * b);
      left = left - b;
    end
    ar_delay = ard; rv_pct = rvp; dup_done = 1'b0; timeout = 1'b1;
    @(posedge clk);
    clear_mon();
    @(negedge clk);
    start_dma = 1'b1; num_trans = BT'(n); start_addr = addr; c0 = cyc;
    @(negedge clk);
    start_dma = 1'b0; num_trans = BT'($urandom); start_addr = $urandom;
    for (int i = 0; i < 40 * n + 400; i++) begin
      @(posedge clk);
      if (dup && !dup_done && (got_data.size() >= 3)) begin
        @(negedge clk);
        start_dma = 1'b1; num_trans = BT'(7); start_addr = 32'h0000_8000;
        @(negedge clk);
        start_dma = 1'b0;
        dup_done = 1'b1;
      end
      if (done_cnt > 0) begin
        timeout = 1'b0;
        break;
      end
    end
    chk($sformatf("n%0d_timeout", n), 64'(timeout), 64'(0));
    repeat (4) @(posedge clk);
    nar = got_ar_addr.size();
    nd = got_data.size();
    chk($sformatf("n%0d_ar_count", n), 64'(nar), 64'(exp_addr.size()));
    for (int i = 0; i < nar && i < exp_addr.size(); i++) begin
      chk($sformatf("n%0d_araddr[%0d]", n, i), 64'(got_ar_addr[i]), 64'(exp_addr[i]));
      chk($sformatf("n%0d_arlen[%0d]", n, i), 64'(got_ar_len[i]), 64'(exp_len[i]));
    end
    chk($sformatf("n%0d_word_count", n), 64'(nd), 64'(n));
    for (int i = 0; i < nd && i < n; i++) begin
      chk($sformatf("n%0d_data[%0d]", n, i), 64'(got_data[i]), 64'(mem_word(addr + 32'(4 * i))));
      chk($sformatf("n%0d_cnt[%0d]", n, i), 64'(got_cnt[i]), 64'(i));
    end
    chk($sformatf("n%0d_vld_without_hs", n), 64'(vld_err), 64'(0));
    chk($sformatf("n%0d_ar_unstable", n), 64'(ar_unstable), 64'(0));
    chk($sformatf("n%0d_done_pulses", n), 64'(done_cnt), 64'(1));
    if (n > 0) chk($sformatf("n%0d_done_timing", n), 64'(done_cyc), 64'(last_vld_cyc + 1));
    else       chk($sformatf("n%0d_done_timing", n), 64'(done_cyc), 64'(c0 + 2));
  endtask

  initial begin
    bit timeout;
    int n;
    rstn = 1'b0; start_dma = 1'b0; num_trans = '0; start_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({M_ARVALID, M_RREADY, data_vld_o, done_o}), 64'(0));
    chk("reset_ar", 64'({M_ARADDR, M_ARLEN}), 64'(0));
    chk("reset_data", 64'({data_o, data_cnt_o}), 64'(0));
    chk("const_ar", 64'({M_ARSIZE, M_ARBURST, M_ARID, M_ARLOCK, M_ARCACHE, M_ARPROT}),
        64'({3'b010, 2'b01, 4'h0, 2'b00, 4'h0, 3'b000}));
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    salt = 32'h0;
    run_xfer(8, 32'h0, 0, 100, 1'b0);
    salt = $urandom;
    run_xfer(128, 32'h0, 1, 100, 1'b0);
    salt = $urandom;
    run_xfer(40, 32'h0000_1000, 0, 100, 1'b0);
    salt = $urandom;
    run_xfer(70, 32'h0000_2000, 5, 40, 1'b0);
    run_xfer(0, 32'h0000_3000, 0, 100, 1'b0);

    for (int k = 0; k < 4; k++) begin
      salt = $urandom;
      n = int'($urandom_range(1, 100));
      run_xfer(n, {18'(0), 7'($urandom_range(0, 127)), 7'b0}, $urandom_range(0, 5),
               $urandom_range(30, 100), 1'b0);
    end

    // Reset in the middle of a long transfer.
    salt = $urandom; ar_delay = 1; rv_pct = 80;
    @(posedge clk);
    clear_mon();
    @(negedge clk);
    start_dma = 1'b1; num_trans = BT'(128); start_addr = 32'h0000_5000;
    @(negedge clk);
    start_dma = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (got_data.size() >= 10) begin
        timeout = 1'b0;
        break;
      end
    end
    chk("midrst_reached", 64'(timeout), 64'(0));
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({M_ARVALID, M_RREADY, data_vld_o, done_o}), 64'(0));
    chk("midrst_ar", 64'({M_ARADDR, M_ARLEN}), 64'(0));
    chk("midrst_data", 64'({data_o, data_cnt_o}), 64'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    salt = $urandom;
    run_xfer(64, 32'h0000_4000, 2, 70, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_dma_rd_engine.md
Name: axi_dma_rd_engine

Overview:
- AXI4 read-only DMA master. Fetches a contiguous block of 32-bit words from external memory (AXI slave) and streams each word to a client on a valid/count interface.
- Used by loaders such as the bias loader. The client issues start_dma with a start address and word count; the engine splits the request into INCR bursts, counts beats and pulses done when complete.

Parameters:
- BITS_TRANS, 18: width of num_trans and data_cnt_o (max words per request 2^18-1).
- OUT_BITS_TRANS, 13: width of internal burst counter; max burst = 2^(BITS_TRANS-OUT_BITS_TRANS) = 32 beats.
- AXI_WIDTH_USER, 1: ARUSER/RUSER width.
- AXI_WIDTH_ID, 4: ARID/RID width.
- AXI_WIDTH_AD, 32: address width.
- AXI_WIDTH_DA, 32: data width.
- AXI_WIDTH_DS, 4: bytes per beat (AXI_WIDTH_DA/8).

Ports:
- clk in 1: clock.
- rstn in 1: async active-low reset.
- M_ARVALID out 1: AR valid.
- M_ARREADY in 1: AR ready.
- M_ARADDR out AD: burst byte address.
- M_ARID out ID: read ID, constant 0.
- M_ARLEN out 8: beats-1.
- M_ARSIZE out 3: constant 3'b010 (4 bytes).
- M_ARBURST out 2: constant 2'b01 (INCR).
- M_ARLOCK out 2: constant 0.
- M_ARCACHE out 4: constant 0.
- M_ARPROT out 3: constant 0.
- M_ARQOS out 4: constant 0.
- M_ARREGION out 4: constant 0.
- M_ARUSER out USER: constant 0.
- M_RVALID in 1: R valid.
- M_RREADY out 1: R ready.
- M_RDATA in DA: read data.
- M_RLAST in 1: last beat of burst.
- M_RID in ID: read ID, ignored.
- M_RUSER in USER: ignored.
- M_RRESP in 2: read response, ignored.
- start_dma in 1: one-cycle request pulse.
- num_trans in BITS_TRANS: number of 32-bit words to read.
- start_addr in AD: byte address of first word, 4-byte aligned.
- data_o out DA: received word.
- data_vld_o out 1: data_o valid.
- data_cnt_o out BITS_TRANS: index of current word, first word = 0.
- done_o out 1: one-cycle completion pulse.

Behaviour:
- Reset (rstn=0, async) clears all of the following:
  - M_ARVALID, M_RREADY, M_ARADDR, M_ARLEN, data_o, data_vld_o, data_cnt_o, done_o.
  - FSM returns to IDLE; counters are cleared.
  - A reset mid-transfer abandons the transfer silently.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - On start_dma=1, latch start_addr and num_trans and clear the word counter.
  - If num_trans=0, go to DONE. Otherwise go to ADDR.
  - start_dma is ignored in every state except IDLE.
- ADDR:
  - Assert M_ARVALID, M_ARADDR = current address, M_ARLEN = min(remaining,32)-1. These values are held stable until M_ARREADY.
  - On handshake: deassert ARVALID, go to DATA, and advance address by beats*AXI_WIDTH_DS.
- DATA:
  - M_RREADY=1 throughout. Only one outstanding burst at a time.
  - Each R handshake (RVALID&RREADY) does the following on the next cycle:
    - data_o <= M_RDATA and data_vld_o=1 for one cycle.
    - data_cnt_o = running word index (0,1,2,...).
    - remaining is decremented.
  - Beat that ends the burst: either RLAST or the burst's beat count reached.
    - If remaining now 0, go to DONE.
    - Otherwise go to ADDR for the next burst.
- DONE: done_o=1 for exactly one cycle (the cycle after the last data_vld_o pulse, or two cycles after start_dma when num_trans=0), then IDLE.
- Latency: R handshake to data_vld_o is 1 cycle. data_vld_o is never asserted without a preceding handshake.
- Bursts are not split at 4 KB; clients keep transfers within one 4 KB region per 32-beat burst (aligned start guarantees this).
- data_cnt_o holds its last value between pulses.

Decomposition:
- Shared package axi_pkg holds the following constants:
  - Burst encodings: AXI_BURST_INCR = 2'b01.
  - AXI_SIZE_4B = 3'b010.
  - MAX_BURST_BEATS = 32.
  - Response codes.
- One natural sub-module: dma_rd_burst_calc. Combinationally computes the next ARLEN and next address from current address and remaining count.

Test Plan:
- Reset then start_dma with num_trans=8, start_addr=0x0, against a memory model holding word k = k:
  - One AR with ARADDR=0, ARLEN=7.
  - 8 data_vld_o pulses with data_o=0..7 and data_cnt_o=0..7.
  - done_o pulses once, the cycle after the last pulse.
- num_trans=128 (bias loader case, 256 16-bit biases):
  - Four ARs, at 0x0/0x80/0x100/0x180, each ARLEN=31.
  - 128 words delivered in order; done_o once.
- num_trans=40:
  - ARs of ARLEN=31 then ARLEN=7, the second at start_addr+0x80.
  - 40 data pulses.
- Backpressure/stalls: ARREADY delayed 5 cycles and RVALID toggled randomly.
  - ARADDR/ARLEN are stable while ARVALID is high.
  - Data pulses occur only on handshakes; the sequence is unchanged.
- num_trans=0: no ARVALID; done_o pulses once, two cycles after start_dma.
- Assert rstn=0 mid-burst:
  - All outputs clear immediately.
  - A new start_dma after reset completes normally.
  - A second start_dma during the transfer is ignored.
